// File: rtl/uart_com_pkg.sv
// Shared UART defaults and the receive word-assembler state encoding.
package uart_com_pkg;

  localparam int BAUD_RATE  = 115_200;
  localparam int UART_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } rx_asm_state_t;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter: counts enabled cycles since the last clear, pulses expire on the
// cycle that completes TIMEOUT_CYCLES idle cycles; saturates, no backpressure.
module rx_timeout_counter #(
  parameter int  TIMEOUT_CYCLES = 5_000_000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The clearing cycle (the byte itself) counts as the first idle cycle boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(1);
    end else if (en && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs UART bytes little-endian into memory words at consecutive addresses; write strobe one
// cycle after a word's final byte, no backpressure. UART_RX_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_word_assembler
  import uart_com_pkg::*;
#(
  parameter int  MEM_WORD_LENGTH = 48,
  parameter int  MEM_DEPTH       = 4096,
  parameter int  UART_WIDTH      = uart_com_pkg::UART_WIDTH,
  parameter int  TIMEOUT_CYCLES  = 5_000_000,
  localparam int BYTES_PER_WORD  = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH,
  localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       use_end_addr,
  input  logic [ADDR_WIDTH-1:0]      end_addr,
  input  logic                       rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0]      byteFromRx,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [MEM_WORD_LENGTH-1:0] dataToMem,
  output logic                       mem_received,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int ASM_W = BYTES_PER_WORD * UART_WIDTH;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  rx_asm_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d, waddr_q, waddr_d, last_q, last_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ASM_W-1:0]           asm_q, asm_d, merged;
  logic [MEM_WORD_LENGTH-1:0] data_q, data_d;
  logic                       err_q, err_d;
  logic                       accept, tmo_expire;

  // During WRITE a byte already belongs to the next word, unless this write ends the session.
  assign accept = rx_new_byte_indicate &&
                  ((state_q == ST_COLLECT) || ((state_q == ST_WRITE) && (addr_q != last_q)));

  always_comb begin
    merged = asm_q;
    merged[idx_q*UART_WIDTH +: UART_WIDTH] = byteFromRx;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    last_d  = last_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = use_end_addr ? end_addr : TOP_ADDR;
          addr_d  = '0;
          waddr_d = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = (addr_q == last_q) ? ST_DONE : ST_COLLECT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // The output word/address are snapshotted here so they hold steady until the next write.
    if (accept) begin
      asm_d = merged;
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        data_d  = merged[MEM_WORD_LENGTH-1:0];
        addr_d  = waddr_q;
        waddr_d = waddr_q + 1'b1;
        state_d = ST_WRITE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic armed_q, armed_d;

  // Silence before the session's first byte never times out.
  assign armed_d = ((state_q == ST_IDLE) && start) ? 1'b0 : (armed_q | accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (armed_q && ((state_q == ST_COLLECT) || (state_q == ST_WRITE))),
    .expire(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  assign mem_wr_en    = (state_q == ST_WRITE);
  assign mem_received = (state_q == ST_DONE);
  assign busy         = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign mem_address  = addr_q;
  assign dataToMem    = data_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Randomized bench for uart_rx_word_assembler: three instances (48-bit, 12-bit and 8-bit words)
// checked against a word-packing reference model built from the byte stream and its timestamps.
module tb_uart_rx_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start_s, rx_s;
  logic        use_end_s;
  logic [2:0]  end_addr_s;
  logic [7:0]  byte_s;
  logic [2:0]  wr_en_s, rcv_s, busy_s, err_s;
  logic [2:0]  addr_a;
  logic [1:0]  addr_b, addr_c;
  logic [47:0] dat_a;
  logic [11:0] dat_b;
  logic [7:0]  dat_c;

  uart_rx_word_assembler #(.MEM_WORD_LENGTH(48), .MEM_DEPTH(8), .UART_WIDTH(8), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .use_end_addr(use_end_s), .end_addr(end_addr_s),
    .rx_new_byte_indicate(rx_s[0]), .byteFromRx(byte_s), .mem_wr_en(wr_en_s[0]), .mem_address(addr_a),
    .dataToMem(dat_a), .mem_received(rcv_s[0]), .busy(busy_s[0]), .timeout_err(err_s[0]));

  uart_rx_word_assembler #(.MEM_WORD_LENGTH(12), .MEM_DEPTH(4), .UART_WIDTH(8), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .use_end_addr(use_end_s), .end_addr(end_addr_s[1:0]),
    .rx_new_byte_indicate(rx_s[1]), .byteFromRx(byte_s), .mem_wr_en(wr_en_s[1]), .mem_address(addr_b),
    .dataToMem(dat_b), .mem_received(rcv_s[1]), .busy(busy_s[1]), .timeout_err(err_s[1]));

  uart_rx_word_assembler #(.MEM_WORD_LENGTH(8), .MEM_DEPTH(4), .UART_WIDTH(8), .TIMEOUT_CYCLES(100)) dut_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .use_end_addr(use_end_s), .end_addr(end_addr_s[1:0]),
    .rx_new_byte_indicate(rx_s[2]), .byteFromRx(byte_s), .mem_wr_en(wr_en_s[2]), .mem_address(addr_c),
    .dataToMem(dat_c), .mem_received(rcv_s[2]), .busy(busy_s[2]), .timeout_err(err_s[2]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int w);
    case (w)
      0:       return 48;
      1:       return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int depth_of(input int w);
    return (w == 0) ? 8 : 4;
  endfunction

  function automatic int bpw_of(input int w);
    return (width_of(w) + 7) / 8;
  endfunction

  function automatic logic [63:0] dat_of(input int w);
    case (w)
      0:       return {16'b0, dat_a};
      1:       return {52'b0, dat_b};
      default: return {56'b0, dat_c};
    endcase
  endfunction

  function automatic int addr_of(input int w);
    case (w)
      0:       return int'(addr_a);
      1:       return int'(addr_b);
      default: return int'(addr_c);
    endcase
  endfunction

  typedef struct {
    int          w;
    int          cyc;
    int          addr;
    logic [63:0] dat;
  } wr_t;

  wr_t wr_q[$];
  int  rc_w[$];
  int  rc_cyc[$];

  always @(negedge clk) begin : monitor
    wr_t e;
    for (int w = 0; w < 3; w++) begin
      if (wr_en_s[w]) begin
        e.w    = w;
        e.cyc  = cyc;
        e.addr = addr_of(w);
        e.dat  = dat_of(w);
        wr_q.push_back(e);
      end
      if (rcv_s[w]) begin
        rc_w.push_back(w);
        rc_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    rc_w.delete();
    rc_cyc.delete();
  endtask

  // One-cycle byte pulse; t is the cycle in which the pulse is presented.
  task automatic send(input int w, input logic [7:0] b, input int gap, input bit with_start, output int t);
    byte_s   = b;
    rx_s[w]  = 1'b1;
    if (with_start) start_s[w] = 1'b1;
    t = cyc;
    tick();
    rx_s[w]    = 1'b0;
    start_s[w] = 1'b0;
    byte_s     = 8'($urandom);
    repeat (gap) tick();
  endtask

  logic [7:0] bytes_q[$];
  int         gaps_q[$];

  task automatic fill(input int n, input int gap, input bit ramp, input logic [7:0] base);
    bytes_q.delete();
    gaps_q.delete();
    for (int i = 0; i < n; i++) begin
      bytes_q.push_back(ramp ? 8'(base + 8'(i)) : 8'($urandom));
      gaps_q.push_back((gap < 0) ? int'($urandom_range(3, 0)) : gap);
    end
  endtask

  task automatic run_session(input int w, input bit use_e, input int ea, input bit pre_junk);
    int          last, nw, bpw, t, tfin;
    int          tb[$];
    logic [63:0] exp, mask;
    clear_mon();
    bpw  = bpw_of(w);
    last = use_e ? ea : depth_of(w) - 1;
    nw   = last + 1;
    if (pre_junk) send(w, 8'h99, 2, 1'b0, t);
    use_end_s  = use_e;
    end_addr_s = 3'(ea);
    start_s[w] = 1'b1;
    tick();
    start_s[w] = 1'b0;
    end_addr_s = 3'($urandom);
    check_eq($sformatf("w%0d_busy_after_start", w), 64'(busy_s[w]), 64'd1);
    for (int i = 0; i < nw * bpw; i++) begin
      send(w, bytes_q[i], gaps_q[i], i == 1, t);
      tb.push_back(t);
    end
    repeat (4) tick();
    mask = (64'd1 << width_of(w)) - 64'd1;
    check_eq($sformatf("w%0d_write_count", w), 64'(wr_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < wr_q.size(); k++) begin
      exp = '0;
      for (int j = 0; j < bpw; j++) exp |= 64'(bytes_q[k*bpw + j]) << (8 * j);
      exp  &= mask;
      tfin  = tb[k*bpw + bpw - 1];
      check_eq($sformatf("w%0d_wr%0d_dut", w, k),   64'(wr_q[k].w), 64'(w));
      check_eq($sformatf("w%0d_wr%0d_addr", w, k),  64'(wr_q[k].addr), 64'(k));
      check_eq($sformatf("w%0d_wr%0d_data", w, k),  wr_q[k].dat, exp);
      check_eq($sformatf("w%0d_wr%0d_cycle", w, k), 64'(wr_q[k].cyc), 64'(tfin + 1));
    end
    check_eq($sformatf("w%0d_received_count", w), 64'(rc_cyc.size()), 64'd1);
    if (rc_cyc.size() > 0) begin
      check_eq($sformatf("w%0d_received_dut", w), 64'(rc_w[0]), 64'(w));
      check_eq($sformatf("w%0d_received_cycle", w), 64'(rc_cyc[0]), 64'(tb[nw*bpw - 1] + 2));
    end
    check_eq($sformatf("w%0d_busy_after_done", w), 64'(busy_s[w]), 64'd0);
  endtask

  initial begin
    int t, t3, w, ea, n;
    bit use_e;
    rst        = 1'b1;
    start_s    = '0;
    rx_s       = '0;
    use_end_s  = 1'b0;
    end_addr_s = '0;
    byte_s     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check_eq("rst_wr_en", 64'(wr_en_s), 64'd0);
    check_eq("rst_received", 64'(rcv_s), 64'd0);
    check_eq("rst_busy", 64'(busy_s), 64'd0);
    check_eq("rst_timeout_err", 64'(err_s), 64'd0);
    check_eq("rst_addr_a", 64'(addr_a), 64'd0);
    check_eq("rst_data_a", 64'(dat_a), 64'd0);
    check_eq("rst_data_b", 64'(dat_b), 64'd0);

    // Three 48-bit words, bytes 0x01..0x12 spaced 20 cycles.
    fill(18, 19, 1'b1, 8'h01);
    run_session(0, 1'b1, 2, 1'b0);
    check_eq("three_words_last", 64'(dat_a), 64'h1211100F0E0D);

    // 12-bit words drop the top nibble of the final byte.
    fill(2, 3, 1'b1, 8'h00);
    bytes_q[0] = 8'hAB;
    bytes_q[1] = 8'hCD;
    run_session(1, 1'b1, 0, 1'b0);
    check_eq("trunc_word", 64'(dat_b), 64'hDAB);

    // Full depth with a stray byte before start.
    fill(4, -1, 1'b1, 8'h10);
    run_session(2, 1'b0, 0, 1'b1);
    check_eq("full_depth_last", 64'(dat_c), 64'h13);

    // Back-to-back bytes: a pulse lands in every write cycle.
    fill(12, 0, 1'b0, 8'h00);
    run_session(0, 1'b1, 1, 1'b0);
    fill(4, 0, 1'b0, 8'h00);
    run_session(2, 1'b0, 0, 1'b0);
    fill(8, 0, 1'b0, 8'h00);
    run_session(1, 1'b0, 0, 1'b0);

    for (int s = 0; s < 10; s++) begin
      w     = int'($urandom_range(2, 0));
      use_e = 1'($urandom_range(1, 0));
      ea    = int'($urandom_range(depth_of(w) - 1, 0));
      n     = (use_e ? ea + 1 : depth_of(w)) * bpw_of(w);
      fill(n, -1, 1'b0, 8'h00);
      run_session(w, use_e, ea, 1'b0);
    end

    // Reset after 4 of 6 bytes discards the partial word.
    clear_mon();
    use_end_s  = 1'b1;
    end_addr_s = 3'd0;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 8'($urandom), 1, 1'b0, t);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("midrst_wr_en", 64'(wr_en_s[0]), 64'd0);
    check_eq("midrst_addr", 64'(addr_a), 64'd0);
    check_eq("midrst_data", 64'(dat_a), 64'd0);
    check_eq("midrst_received", 64'(rcv_s[0]), 64'd0);
    check_eq("midrst_busy", 64'(busy_s[0]), 64'd0);
    check_eq("midrst_no_write", 64'(wr_q.size()), 64'd0);
    fill(6, 2, 1'b1, 8'hA0);
    run_session(0, 1'b1, 0, 1'b0);
    check_eq("midrst_new_word", 64'(dat_a), 64'hA5A4A3A2A1A0);

    // Three bytes then silence.
    clear_mon();
    use_end_s  = 1'b1;
    end_addr_s = 3'd1;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    send(0, 8'($urandom), 2, 1'b0, t);
    send(0, 8'($urandom), 2, 1'b0, t);
    send(0, 8'($urandom), 0, 1'b0, t3);
    repeat (98) tick();
`ifdef UART_RX_TIMEOUT_EN
    check_eq("tmo_busy_before", 64'(busy_s[0]), 64'd1);
    check_eq("tmo_err_before", 64'(err_s[0]), 64'd0);
    tick();
    check_eq("tmo_cycle", 64'(cyc - t3), 64'd100);
    check_eq("tmo_busy_after", 64'(busy_s[0]), 64'd0);
    check_eq("tmo_err_after", 64'(err_s[0]), 64'd1);
    repeat (5) tick();
    check_eq("tmo_err_sticky", 64'(err_s[0]), 64'd1);
    check_eq("tmo_no_write", 64'(wr_q.size()), 64'd0);
    check_eq("tmo_no_received", 64'(rc_cyc.size()), 64'd0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check_eq("tmo_err_cleared", 64'(err_s[0]), 64'd0);
`else
    repeat (60) tick();
    check_eq("notmo_busy", 64'(busy_s[0]), 64'd1);
    check_eq("notmo_err", 64'(err_s[0]), 64'd0);
    check_eq("notmo_no_write", 64'(wr_q.size()), 64'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("final_busy", 64'(busy_s), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

Receive-side packer between `uart_system` and a memory write port. It takes the stream of UART bytes (`rx_new_byte_indicate` / `byteFromRx`), packs them little-endian into `MEM_WORD_LENGTH`-bit words and writes each word to consecutive addresses starting at 0. It stops after the programmed end address and signals completion with a single pulse. It is the front half of the data-memory and instruction-memory load path, and feeds the memory mux directly in the top-level state `uart_receive_dmem` / `uart_receive_Imem`.

## Interface
Parameters:
- `MEM_WORD_LENGTH`, 48, width of one memory word.
- `MEM_DEPTH`, 4096, number of memory words.
- `UART_WIDTH`, 8, bits per received byte.
- `TIMEOUT_CYCLES`, 5_000_000, inter-byte timeout (100 ms at 50 MHz); used only with the macro.
- Derived `BYTES_PER_WORD` = ceil(`MEM_WORD_LENGTH`/`UART_WIDTH`).
- Derived `ADDR_WIDTH` = $clog2(`MEM_DEPTH`).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (`CLOCK_50`).
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle pulse that arms a receive session.
- `use_end_addr`  in  1  1: stop at `end_addr`; 0: stop at `MEM_DEPTH-1`.
- `end_addr`  in  `ADDR_WIDTH`  last address to write; sampled on `start`.
- `rx_new_byte_indicate`  in  1  one-cycle pulse, new byte valid.
- `byteFromRx`  in  `UART_WIDTH`  received byte.
- `mem_wr_en`  out  1  memory write strobe.
- `mem_address`  out  `ADDR_WIDTH`  write address.
- `dataToMem`  out  `MEM_WORD_LENGTH`  assembled word.
- `mem_received`  out  1  one-cycle pulse after the final write.
- `busy`  out  1  session active (COLLECT or WRITE).
- `timeout_err`  out  1  sticky timeout flag; tied to 0 without the macro.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - Bytes are ignored.
  - `start` latches the last address (`end_addr` if `use_end_addr` is 1, else `MEM_DEPTH-1`), clears the address, the byte index and `timeout_err`, then goes to COLLECT.
- COLLECT:
  - Each byte is shifted into the lane given by the byte index; the first byte of a word goes to bits [UART_WIDTH-1:0].
  - When the byte index reaches `BYTES_PER_WORD-1`, the state goes to WRITE.
- Final-byte truncation: bits of the last byte above `MEM_WORD_LENGTH` are discarded.
- WRITE (one cycle):
  - `mem_wr_en`=1.
  - If the address equals the latched last address, go to DONE.
  - Otherwise increment the address and return to COLLECT.
  - A byte arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- DONE (one cycle): `mem_received`=1, then go to IDLE.
- `start` while `busy` is 1 is ignored.
- `end_addr` changes after `start` have no effect.
- The address never wraps, because the latched last address is ≤ `MEM_DEPTH-1`.
- `rst` at any time returns to IDLE and clears all registers; any partial word is discarded.

## Timing
- Reset values: `mem_wr_en`=0, `mem_address`=0, `dataToMem`=0, `mem_received`=0, `busy`=0, `timeout_err`=0.
- Final byte of a word on `rx_new_byte_indicate` at cycle t:
  - `mem_wr_en` is high at cycle t+1.
  - `mem_address` and `dataToMem` are registered and stable for that whole cycle.
- Final word: `mem_received` is high at t+2 and `busy` is low from t+2.
- `dataToMem` and `mem_address` hold their values between writes.
- Byte index: registered, 0..`BYTES_PER_WORD-1`.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - An idle counter runs in COLLECT and clears on every byte.
  - It is armed only after the session's first byte.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, set `timeout_err` (sticky until the next `start` or `rst`), discard the partial word, and do not assert `mem_received`.
- Undefined: no counter; `timeout_err` is constant 0; COLLECT waits indefinitely.

## Structure
- Shared package `uart_com_pkg`:
  - `rx_asm_state_t` enum.
  - `BAUD_RATE` and `UART_WIDTH` defaults shared with `uart_system` and `mem_communication_interface`.
- Sub-module `rx_timeout_counter` (clear, enable, `TIMEOUT_CYCLES` parameter, expire pulse); instantiated only under `UART_RX_TIMEOUT_EN`.

## Test plan
- **Three 48-bit words:** `MEM_WORD_LENGTH`=48, `use_end_addr`=1, `end_addr`=2, `start`, then bytes 0x01..0x12 spaced 20 cycles.
  - Writes: addr0=0x060504030201, addr1=0x0C0B0A090807, addr2=0x1211100F0E0D.
  - One `mem_received` pulse, 2 cycles after byte 0x12.
- **Width truncation:** `MEM_WORD_LENGTH`=12, `end_addr`=0, bytes 0xAB, 0xCD.
  - `dataToMem`=12'hDAB at addr0; `mem_received` at t+2.
- **Full-depth stop:** `use_end_addr`=0, `MEM_DEPTH`=4, width 8, bytes 0x10..0x13, and 0x99 before `start`.
  - 0x99 is ignored.
  - Addresses 0..3 are written with 0x10..0x13.
  - `mem_received` follows the addr3 write.
- **Byte during WRITE:** a byte pulse in the same cycle as `mem_wr_en` becomes byte 0 of the next word; the next word's value is checked.
- **Reset mid-session:** `rst` after 4 of 6 bytes.
  - All outputs return to 0.
  - A new `start` plus 6 bytes 0xA0..0xA5 writes 0xA5A4A3A2A1A0 to addr0.
- **Timeout (with `UART_RX_TIMEOUT_EN`):** `TIMEOUT_CYCLES`=100, 3 bytes then silence.
  - `timeout_err`=1 and `busy`=0 exactly 100 cycles after the third byte.
  - No write and no `mem_received`.
